// File: rtl/debounce_pkg.sv
// Shared types and helpers for the scanned button debouncer.
package debounce_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_BIT   = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_scan_ctrl_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
    import debounce_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [CHW-1:0] i_ptr,
    output logic [CHW-1:0] o_grant,
    output logic           o_any
);

    // Walk offsets from far to near so the nearest request overwrites the rest.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_req[(int'(i_ptr) + i) % NCH]) begin
                o_grant = CHW'((int'(i_ptr) + i) % NCH);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed button debouncer with round-robin press-event handshake.
// Auto-repeat while held is built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int HIST      = 4,
    parameter int DIV       = 5000000,
    parameter int DIV_W     = 25,
    parameter int REP_TICKS = 50
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NCH-1:0]        i_btn,
    output logic [NCH-1:0]        o_level,
    output logic                  o_evt_valid,
    output logic [clog2(NCH)-1:0] o_evt_ch,
    input  logic                  i_evt_ready,
    output logic [NCH-1:0]        o_overrun,
    input  logic                  i_ovr_clr,
    output logic                  o_busy
);

    localparam int             CHW     = clog2(NCH);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

    if (DIV <= NCH + 1 || HIST < 2 || REP_TICKS < 1) begin : g_param_check
        $error("debounce_scan_ctrl: illegal parameter combination");
    end

    state_t           r_state;
    logic [CHW-1:0]   r_ch;
    logic [CHW-1:0]   r_ptr;
    logic [CHW-1:0]   r_evt_ch;
    logic [DIV_W-1:0] r_cnt;
    logic [NCH-1:0]   r_sync1;
    logic [NCH-1:0]   r_sync2;
    logic [NCH-1:0]   r_level;
    logic [NCH-1:0]   r_pend;
    logic [NCH-1:0]   r_overrun;
    logic [HIST-1:0]  r_hist [NCH];
    logic             r_evt_valid;
    logic             r_busy;

    logic             w_tick;
    logic             w_scan;
    logic [HIST-1:0]  w_hist_new;
    logic             w_lvl_new;
    logic             w_press;
    logic             w_rep_hit;
    logic             w_set;
    logic             w_consume;
    logic [NCH-1:0]   w_set_vec;
    logic [NCH-1:0]   w_clr_vec;
    logic [CHW-1:0]   w_grant;
    logic             w_any;

    assign w_tick     = (r_cnt == DIV_W'(DIV - 1));
    assign w_scan     = (r_state == ST_SCAN);
    assign w_hist_new = {r_hist[r_ch][HIST-2:0], r_sync2[r_ch]};
    // All ones sets, all zeros clears, any mix holds the previous level.
    assign w_lvl_new  = (&w_hist_new) | (r_level[r_ch] & (|w_hist_new));
    assign w_press    = w_scan & w_lvl_new & ~r_level[r_ch];

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int REPW = clog2(REP_TICKS + 1);
    logic [REPW-1:0] r_rep [NCH];

    assign w_rep_hit = w_scan & w_lvl_new & r_level[r_ch]
                     & (r_rep[r_ch] == REPW'(REP_TICKS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NCH; i++) r_rep[i] <= '0;
        end else if (w_scan) begin
            if (!w_lvl_new || w_rep_hit) r_rep[r_ch] <= '0;
            else if (r_level[r_ch])      r_rep[r_ch] <= r_rep[r_ch] + REPW'(1);
        end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    assign w_set     = w_press | w_rep_hit;
    assign w_consume = r_evt_valid & i_evt_ready;
    assign w_set_vec = w_set     ? (NCH'(1) << r_ch)     : '0;
    assign w_clr_vec = w_consume ? (NCH'(1) << r_evt_ch) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_cnt   <= w_tick ? '0 : r_cnt + DIV_W'(1);
        end
    end

    // A tick arriving while scanning is simply not looked at.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RST_STATE;
            r_ch    <= '0;
            r_busy  <= RST_BIT;
            r_level <= '0;
            for (int i = 0; i < NCH; i++) r_hist[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_SCAN;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    r_hist[r_ch]  <= w_hist_new;
                    r_level[r_ch] <= w_lvl_new;
                    if (r_ch == LAST_CH) begin
                        r_state <= ST_IDLE;
                        r_ch    <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ch <= r_ch + CHW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .i_req   (r_pend),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // Set beats a same-edge consume of the same channel, and that is not an overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend      <= '0;
            r_overrun   <= '0;
            r_ptr       <= '0;
            r_evt_valid <= RST_BIT;
            r_evt_ch    <= '0;
        end else begin
            r_pend    <= (r_pend & ~w_clr_vec) | w_set_vec;
            r_overrun <= (i_ovr_clr ? '0 : r_overrun) | (w_set_vec & r_pend & ~w_clr_vec);
            if (w_consume) begin
                r_evt_valid <= 1'b0;
                r_ptr       <= (r_evt_ch == LAST_CH) ? '0 : r_evt_ch + CHW'(1);
            end else if (!r_evt_valid && w_any) begin
                r_evt_valid <= 1'b1;
                r_evt_ch    <= w_grant;
            end
        end
    end

    assign o_level     = r_level;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_ch    = r_evt_ch;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Self-checking bench for debounce_scan_ctrl: directed scenarios plus random traffic
// against a queue-based behavioural model; honours DEBOUNCE_AUTOREPEAT_EN.
module tb_debounce_scan_ctrl;

    localparam int NCH = 4, HIST = 4, DIV = 8, DIV_W = 4, REP_TICKS = 3;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int EXP_T2 = 3;
`else
    localparam int EXP_T2 = 1;
`endif

    logic           clk = 1'b0;
    logic           rst, ready, ovr_clr;
    logic [NCH-1:0] btn;
    logic [NCH-1:0] o_level, o_overrun;
    logic           o_evt_valid, o_busy;
    logic [1:0]     o_evt_ch;

    int checks = 0;
    int errors = 0;

    debounce_scan_ctrl #(
        .NCH(NCH), .HIST(HIST), .DIV(DIV), .DIV_W(DIV_W), .REP_TICKS(REP_TICKS)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn       (btn),
        .o_level     (o_level),
        .o_evt_valid (o_evt_valid),
        .o_evt_ch    (o_evt_ch),
        .i_evt_ready (ready),
        .o_overrun   (o_overrun),
        .i_ovr_clr   (ovr_clr),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: scan slot timing from the edge count since reset,
    // debounce from a queue of the last HIST samples per channel.
    bit             m_init = 0;
    int             k;
    bit [NCH-1:0]   b1, b2, samp, m_level, m_pend, m_ovr, nxt_pend, nxt_ovr;
    bit             m_valid, m_busy, cons, newl, found;
    int             m_ch, m_ptr, c, set_ch, ones;
    int             m_rep [NCH];
    bit             hq [NCH][$];

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; k = 0; b1 = '0; b2 = '0;
            m_level = '0; m_pend = '0; m_ovr = '0;
            m_valid = 0; m_busy = 0; m_ch = 0; m_ptr = 0;
            for (int i = 0; i < NCH; i++) begin
                m_rep[i] = 0;
                hq[i].delete();
                for (int j = 0; j < HIST; j++) hq[i].push_back(1'b0);
            end
        end else begin
            samp = b2; b2 = b1; b1 = btn;
            k++;
            cons = m_valid && ready;
            set_ch = -1;
            if (k >= DIV + 1 && (k % DIV) >= 1 && (k % DIV) <= NCH) begin
                c = (k % DIV) - 1;
                hq[c].push_back(samp[c]);
                void'(hq[c].pop_front());
                ones = 0;
                for (int j = 0; j < hq[c].size(); j++) ones += int'(hq[c][j]);
                newl = m_level[c];
                if (ones == HIST) newl = 1;
                else if (ones == 0) newl = 0;
                if (newl && !m_level[c]) set_ch = c;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                if (!newl) m_rep[c] = 0;
                else if (m_level[c]) begin
                    m_rep[c]++;
                    if (m_rep[c] == REP_TICKS) begin m_rep[c] = 0; set_ch = c; end
                end
`endif
                m_level[c] = newl;
            end
            nxt_pend = m_pend;
            nxt_ovr  = ovr_clr ? '0 : m_ovr;
            if (cons) nxt_pend[m_ch] = 0;
            if (set_ch >= 0) begin
                if (m_pend[set_ch] && !(cons && m_ch == set_ch)) nxt_ovr[set_ch] = 1;
                else nxt_pend[set_ch] = 1;
            end
            if (cons) begin
                m_valid = 0;
                m_ptr = (m_ch + 1) % NCH;
            end else if (!m_valid && m_pend != 0) begin
                found = 0;
                for (int i = 0; i < NCH; i++) begin
                    if (!found && m_pend[(m_ptr + i) % NCH]) begin
                        found = 1; m_ch = (m_ptr + i) % NCH;
                    end
                end
                m_valid = 1;
            end
            m_pend = nxt_pend;
            m_ovr  = nxt_ovr;
            m_busy = (k >= DIV) && ((k % DIV) < NCH);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("level",     int'(o_level),     int'(m_level));
            chk("evt_valid", int'(o_evt_valid), int'(m_valid));
            chk("evt_ch",    int'(o_evt_ch),    m_ch);
            chk("overrun",   int'(o_overrun),   int'(m_ovr));
            chk("busy",      int'(o_busy),      int'(m_busy));
        end
    end

    int got[$];
    int ndel = 0;
    always @(posedge clk) begin
        if (!rst && o_evt_valid && ready) begin
            got.push_back(int'(o_evt_ch));
            ndel++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int snap;
    bit seen;

    initial begin
        rst = 1; btn = '0; ready = 0; ovr_clr = 0;
        idle(3);
        chk("rst_level", int'(o_level), 0);
        chk("rst_valid", int'(o_evt_valid), 0);
        chk("rst_busy",  int'(o_busy), 0);

        // held button on ch2 from the first edge after reset
        btn = 4'b0100; ready = 1; rst = 0;
        idle(34);
        chk("t2_level_before", int'(o_level[2]), 0);
        idle(1);
        chk("t2_level_rise", int'(o_level[2]), 1);
        idle(1);
        chk("t2_valid", int'(o_evt_valid), 1);
        chk("t2_ch", int'(o_evt_ch), 2);
        idle(64);
        chk("t2_events", ndel, EXP_T2);
        btn = '0;
        idle(60);

        // reset in the middle of a scan
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = o_busy;
        end
        chk("t1_busy_seen", int'(seen), 1);
        rst = 1;
        idle(3);
        chk("t1_rst_busy",  int'(o_busy), 0);
        chk("t1_rst_level", int'(o_level), 0);
        rst = 0;
        idle(7);
        chk("t1_busy_early", int'(o_busy), 0);
        idle(1);
        chk("t1_busy_first", int'(o_busy), 1);

        // bouncing ch1 never debounces
        snap = ndel;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn[1] = ~btn[1];
            @(negedge clk);
        end
        btn = '0;
        idle(50);
        chk("t3_level1", int'(o_level[1]), 0);
        chk("t3_no_events", ndel, snap);

        // simultaneous ch0+ch3, consumer stalled
        ready = 0; got.delete();
        btn = 4'b1001;
        idle(100);
        chk("t4_hold_valid", int'(o_evt_valid), 1);
        chk("t4_hold_ch", int'(o_evt_ch), 0);
        ready = 1;
        idle(10);
        chk("t4_count", int'(got.size() >= 2), 1);
        if (got.size() >= 2) begin
            chk("t4_first", got[0], 0);
            chk("t4_second", got[1], 3);
        end
        btn = '0;
        idle(60);

        // ch1 occupies the output while ch0 and ch3 queue up behind it
        ready = 0; got.delete();
        btn = 4'b0010;
        idle(50);
        btn = 4'b1011;
        idle(50);
        ready = 1;
        idle(10);
        chk("t4b_count", int'(got.size() >= 3), 1);
        if (got.size() >= 3) begin
            chk("t4b_first", got[0], 1);
            chk("t4b_second", got[1], 3);
            chk("t4b_third", got[2], 0);
        end
        btn = '0;
        idle(60);

        // lost press on ch1 raises sticky overrun
        ovr_clr = 1; idle(1); ovr_clr = 0;
        ready = 0; got.delete();
        btn = 4'b0010;
        idle(50);
        btn = '0;
        idle(60);
        btn = 4'b0010;
        idle(50);
        chk("t5_overrun", int'(o_overrun), 2);
        ovr_clr = 1; idle(1); ovr_clr = 0;
        chk("t5_cleared", int'(o_overrun), 0);
        ready = 1;
        idle(10);
`ifndef DEBOUNCE_AUTOREPEAT_EN
        chk("t5_one_event", got.size(), 1);
`endif
        btn = '0;
        idle(60);

        // random traffic against the model
        for (int s = 0; s < 150; s++) begin
            int hold;
            btn  = 4'($urandom);
            hold = $urandom_range(4, 40);
            for (int t = 0; t < hold; t++) begin
                ready   = ($urandom_range(0, 3) != 0);
                ovr_clr = ($urandom_range(0, 31) == 0);
                rst     = ($urandom_range(0, 299) == 0);
                @(negedge clk);
            end
        end
        rst = 0; ovr_clr = 0; btn = '0;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
